// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, instruction-queue entry layout
// and the PC alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  localparam int          IQ_ENTRY_WIDTH = 64;
  localparam logic [31:0] FETCH_RESET_PC = 32'h1ECE_B000;

  // Fetch addresses are always word aligned; low two bits of any incoming PC are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word read at a time and writes {pc, inst}
// into the instruction queue. Optional one-entry skid register enabled by FETCH_SKID_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        iq_wen,
  output logic [63:0] iq_wdata,
  input  logic        iq_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  state_o
);

  // Handshakes: a request is the single cycle imem_rmask==4'hF (addr valid only then);
  // imem_resp is a one-cycle strobe qualifying imem_rdata; iq_wen is a one-cycle write with
  // no back-pressure, so the unit must only assert it when the queue has room.

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         issue_ok;
  iq_entry_t    wentry;

`ifdef FETCH_SKID_EN
  logic         skid_valid_q, skid_valid_d;
  iq_entry_t    skid_q, skid_d;

  // With a skid, a full queue at response time is absorbed, so issue only waits on the skid.
  assign issue_ok = !skid_valid_q;
`else
  assign issue_ok = !iq_full;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_addr  = '0;
    imem_rmask = 4'h0;
    iq_wen     = 1'b0;
    wentry     = '0;
`ifdef FETCH_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
`endif
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
          end else begin
`ifdef FETCH_SKID_EN
            if (skid_valid_q && !iq_full) begin
              iq_wen       = 1'b1;
              wentry       = skid_q;
              skid_valid_d = 1'b0;
            end
`endif
            if (issue_ok) begin
              imem_rmask = 4'hF;
              imem_addr  = pc_q;
              state_d    = WAIT;
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_d    = align_pc(redirect_pc);
            state_d = imem_resp ? IDLE : DROP;
          end else if (imem_resp) begin
`ifdef FETCH_SKID_EN
            if (iq_full) begin
              skid_valid_d = 1'b1;
              skid_d.pc    = pc_q;
              skid_d.inst  = imem_rdata;
            end else begin
              iq_wen      = 1'b1;
              wentry.pc   = pc_q;
              wentry.inst = imem_rdata;
            end
`else
            iq_wen      = 1'b1;
            wentry.pc   = pc_q;
            wentry.inst = imem_rdata;
`endif
            pc_d    = pc_q + 32'd4;
            state_d = IDLE;
          end
        end
        DROP: begin
          // The stale response still has to be absorbed before a new request may go out.
          if (redirect_valid) pc_d = align_pc(redirect_pc);
          if (imem_resp) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
`ifdef FETCH_SKID_EN
      if (redirect_valid) skid_valid_d = 1'b0;
`endif
    end
  end

  assign iq_wdata = wentry;
  assign state_o  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= align_pc(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory latency, queue drain and redirects against a
// PC-sequence reference model, with a scoreboard of expected queue entries.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] EXP_RESET_PC = 32'h1ECE_B000;
  localparam int          IQ_DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        iq_wen;
  logic [63:0] iq_wdata;
  logic        iq_full = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  state_o;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .iq_wen         (iq_wen),
    .iq_wdata       (iq_wdata),
    .iq_full        (iq_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // Reference model: the PC the next fetch must use, and the memory's view of the request.
  logic [31:0] model_pc = EXP_RESET_PC;
  bit outstanding = 0, drop_pending = 0, cyc_busy = 0, resp_real = 0, resp_pushed = 0;
  int wait_cnt = 0;
  int iq_count = 0;

  int lat_min = 1, lat_max = 1, redir_pct = 0, drain_pct = 100;
  bit hold_full = 0, spurious_en = 0, rst_req = 1, force_redir = 0;
  logic [31:0] force_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cycle();
    logic [31:0] r;
    @(posedge clk);
    #1;
    rst            = rst_req;
    imem_resp      = 1'b0;
    imem_rdata     = $urandom;
    redirect_valid = 1'b0;
    r              = $urandom;
    redirect_pc    = r;
    resp_real      = 0;
    resp_pushed    = 0;
    if (iq_count > 0 && $urandom_range(99) < drain_pct) iq_count--;
    iq_full = hold_full || (iq_count >= IQ_DEPTH);
    if (rst_req) begin
      outstanding  = 0;
      drop_pending = 0;
      cyc_busy     = 0;
      model_pc     = EXP_RESET_PC;
      exp_q.delete();
      if (spurious_en && $urandom_range(1) == 1) imem_resp = 1'b1;
    end else begin
      cyc_busy = outstanding;
      if (force_redir || $urandom_range(99) < redir_pct) begin
        redirect_valid = 1'b1;
        if (force_redir) redirect_pc = force_pc;
        else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
        force_redir = 0;
      end
      if (outstanding) begin
        if (wait_cnt <= 1) begin
          imem_resp   = 1'b1;
          outstanding = 0;
          resp_real   = 1;
          if (!drop_pending && !redirect_valid) begin
            exp_q.push_back({model_pc, imem_rdata});
            model_pc    = model_pc + 32'd4;
            resp_pushed = 1;
          end
          drop_pending = 0;
        end else begin
          wait_cnt--;
        end
      end else if (spurious_en && $urandom_range(99) < 5) begin
        imem_resp = 1'b1;
      end
      if (redirect_valid) begin
        model_pc = redirect_pc & 32'hFFFF_FFFC;
        if (outstanding) drop_pending = 1;
`ifdef FETCH_SKID_EN
        exp_q.delete();
`endif
      end
    end
  endtask

  // Monitor: issue legality, request address, and every queue write against the scoreboard.
  always @(negedge clk) begin
    logic exp_issue;
    if (!rst) begin
`ifdef FETCH_SKID_EN
      exp_issue = !cyc_busy && !redirect_valid && (exp_q.size() == 0);
`else
      exp_issue = !cyc_busy && !redirect_valid && !iq_full;
`endif
      check("issue_rmask", imem_rmask, exp_issue ? 4'hF : 4'h0);
      if (imem_rmask == 4'hF) begin
        check("req_addr", imem_addr, model_pc);
        outstanding = 1;
        wait_cnt    = $urandom_range(lat_max, lat_min);
      end
      if (resp_real) check("wen_on_resp", iq_wen, resp_pushed && !iq_full);
      if (iq_wen) begin
        check("wen_while_full", iq_full, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got %h expected no write", iq_wdata);
        end else begin
          check("iq_entry", iq_wdata, exp_q.pop_front());
        end
        iq_count++;
      end
    end
  end

  task automatic wait_for_busy(input int need_cnt, input string name);
    int n = 0;
    while (!(outstanding && (need_cnt == 0 || wait_cnt == need_cnt)) && n < 40) begin
      drive_cycle();
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s: got no request in flight after %0d cycles expected one", name, n);
    end
  endtask

  initial begin
    spurious_en = 1;
    rst_req     = 1;
    repeat (3) begin
      drive_cycle();
      @(negedge clk);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_rmask", imem_rmask, 4'h0);
      check("rst_wen", iq_wen, 1'b0);
      check("rst_wdata", iq_wdata, 64'h0);
      check("rst_state", state_o, IDLE);
    end

    // Queue full out of reset: no fetch until it clears.
    spurious_en = 0;
    hold_full   = 1;
    rst_req     = 0;
    repeat (6) drive_cycle();
    hold_full = 0;

    // Fixed latency 1: one instruction every two cycles from the reset PC.
    lat_min = 1; lat_max = 1; drain_pct = 100;
    repeat (20) drive_cycle();

    // Redirect to an unaligned target while a latency-3 fetch is in flight.
    lat_min = 3; lat_max = 3;
    wait_for_busy(0, "wait_busy_l3");
    force_pc = 32'h0000_1002; force_redir = 1;
    repeat (12) drive_cycle();

    // Redirect in the same cycle as the response.
    lat_min = 2; lat_max = 2;
    wait_for_busy(1, "wait_resp_cycle");
    force_pc = 32'h0000_4000; force_redir = 1;
    repeat (10) drive_cycle();

    // Fetch at the top of the address space wraps to zero.
    lat_min = 1; lat_max = 2;
    force_pc = 32'hFFFF_FFFC; force_redir = 1;
    repeat (12) drive_cycle();

    // Random traffic with a mid-run reset.
    lat_min = 1; lat_max = 4; redir_pct = 8; drain_pct = 40; spurious_en = 1;
    repeat (700) drive_cycle();
    rst_req = 1;
    repeat (2) drive_cycle();
    @(negedge clk);
    check("midrst_state", state_o, IDLE);
    rst_req = 0;
    repeat (800) drive_cycle();

    // Quiesce and confirm every expected entry was written.
    redir_pct = 0; drain_pct = 100; spurious_en = 0;
    repeat (30) drive_cycle();
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
